neuron_mac_seq: RTL
===================

NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 The parameter N_TERMS SHALL default to 8 and set the number of weight/input products per dot product; it SHALL be at least 1.
REQ-002 The parameter RELU SHALL default to 1; 1 applies max(0, acc) to the result, 0 passes the accumulator unchanged.
REQ-003 Number formats SHALL use the codebase macros `NUM_WIDTH, `INT_WIDTH, `FRAC_WIDTH and `MUL_INT_WIDTH (two's-complement fixed point).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse; loads bias and begins a dot product.
REQ-007 bias  input  `NUM_WIDTH  accumulator initial value, sampled on an accepted start.
REQ-008 in_valid  input  1  x/w pair valid.
REQ-009 in_ready  output  1  block accepts a pair this cycle.
REQ-010 x  input  `NUM_WIDTH  activation operand.
REQ-011 w  input  `NUM_WIDTH  weight operand.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream (max stage / next layer) accepts the result.
REQ-014 out_val  output  `NUM_WIDTH  activated dot product.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, ACC, ACT and HOLD.
REQ-017 IDLE: in_ready=0; start SHALL load acc<=bias and cnt<=0, then move to ACC.
REQ-018 ACC: in_ready=1; on in_valid&in_ready, acc SHALL become add_sat(acc, mul_sat(x,w)) and cnt SHALL increment.
REQ-019 ACC: acceptance of term N_TERMS-1 SHALL move the FSM to ACT; in_valid low SHALL stall the FSM with acc and cnt held.
REQ-020 ACT: one cycle; it SHALL register out_val = (RELU && acc[MSB]) ? 0 : acc, then move to HOLD.
REQ-021 HOLD: out_valid=1 and out_val SHALL stay stable until out_ready; out_valid&out_ready SHALL return the FSM to IDLE.
REQ-022 A result that is not taken SHALL stall the FSM in HOLD indefinitely with no loss of data.
REQ-023 Latency from the last accepted pair to out_valid SHALL be 2 cycles (ACT, then HOLD).
REQ-024 The minimum start-to-start period SHALL be N_TERMS+3 cycles, with out_ready held high and in_valid held high.
REQ-025 Arithmetic: the multiply and the add SHALL each saturate to the most-positive or most-negative value, with no wrap; a saturated acc SHALL still accept later terms, so positive/negative terms move it back off the rail.
REQ-026 start outside IDLE SHALL be ignored, with no restart and no state change.
REQ-027 in_valid in IDLE, ACT or HOLD SHALL be ignored and no pair SHALL be consumed.
REQ-028 cnt SHALL be $clog2(N_TERMS+1) bits wide and SHALL never exceed N_TERMS-1 in ACC.

Reset
REQ-029 While rst_n=0: state=IDLE, acc=0, cnt=0, out_val=0, out_valid=0, in_ready=0, busy=0.
REQ-030 Reset asserted mid-dot-product SHALL abort immediately; after release the block SHALL be in IDLE with no pending result.

Structure
REQ-031 The number-format macros and the FSM state encoding SHALL reside in the shared defines/package; N_TERMS and RELU SHALL remain local parameters.
REQ-032 The datapath SHALL instantiate the existing mul_sat_comb and add_sat_comb and SHALL add no new arithmetic sub-module.
REQ-033 Registered outputs: out_val, out_valid. Combinational decodes of state: in_ready, busy.

Verification (all values at NUM_WIDTH=16, FRAC_WIDTH=8)
REQ-034 N_TERMS=4, bias=0x0100, four pairs x=0x0200 w=0x0080 -> out_val=0x0500, with out_valid 2 cycles after the 4th pair.
REQ-035 bias=0x0000, four pairs x=0xFF00 (-1.0) w=0x0100, RELU=1 -> out_val=0x0000; the same stimulus with RELU=0 -> out_val=0xFC00.
REQ-036 Pairs x=0x7FFF w=0x7FFF -> acc pinned at 0x7FFF; then one pair x=0xFF00 w=0x0100 -> acc=0x7EFF.
REQ-037 in_valid toggled 1-0-1-0 and out_ready held low for 5 cycles -> exactly N_TERMS pairs consumed; out_val stable through HOLD; IDLE reached the cycle after out_ready rises.
REQ-038 start pulsed in ACC, then rst_n pulsed low after 2 accepted pairs -> the start has no effect; after reset release out_valid=0 and state=IDLE; a fresh start yields a correct result.

Source files
------------

// File: rtl/neuron_mac_seq_pkg.sv
// Shared definitions for the neuron MAC sequencer.
//   - Fixed-point number format macros (two's complement, Q INT.FRAC).
//   - FSM state encoding and saturation rails used by the datapath.
// No ports; imported by every design file of this block.

`ifndef NUM_WIDTH
`define NUM_WIDTH 16
`endif
`ifndef INT_WIDTH
`define INT_WIDTH 8
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 8
`endif
`ifndef MUL_INT_WIDTH
`define MUL_INT_WIDTH (2*`INT_WIDTH)
`endif

package neuron_mac_seq_pkg;

    localparam int NUM_W = `NUM_WIDTH;

    // Saturation rails of the number format.
    localparam logic [`NUM_WIDTH-1:0] NUM_MAX = {1'b0, {(`NUM_WIDTH-1){1'b1}}};
    localparam logic [`NUM_WIDTH-1:0] NUM_MIN = {1'b1, {(`NUM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ACT  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_mac_seq_arith.sv
// Saturating fixed-point arithmetic used by the MAC datapath.
//   mul_sat_comb : p = sat(a * b), full-precision product re-aligned by FRAC bits
//                  (arithmetic shift, i.e. round toward -inf).
//     a, b : `NUM_WIDTH operands    p : `NUM_WIDTH result
//   add_sat_comb : s = sat(a + b)
//     a, b : `NUM_WIDTH operands    s : `NUM_WIDTH result

module mul_sat_comb
    import neuron_mac_seq_pkg::*;
(
    input  logic [`NUM_WIDTH-1:0] a,
    input  logic [`NUM_WIDTH-1:0] b,
    output logic [`NUM_WIDTH-1:0] p
);
    localparam int PW = `MUL_INT_WIDTH + 2*`FRAC_WIDTH;

    logic signed [PW-1:0] a_ext, b_ext, prod, shr;

    assign a_ext = PW'($signed(a));
    assign b_ext = PW'($signed(b));
    assign prod  = a_ext * b_ext;
    assign shr   = prod >>> `FRAC_WIDTH;

    always_comb begin
        p = shr[`NUM_WIDTH-1:0];
        // In range only if every bit above the result MSB is a copy of it.
        if (shr[PW-1:`NUM_WIDTH-1] != {(PW-`NUM_WIDTH+1){shr[PW-1]}})
            p = shr[PW-1] ? NUM_MIN : NUM_MAX;
    end
endmodule

module add_sat_comb
    import neuron_mac_seq_pkg::*;
(
    input  logic [`NUM_WIDTH-1:0] a,
    input  logic [`NUM_WIDTH-1:0] b,
    output logic [`NUM_WIDTH-1:0] s
);
    logic [`NUM_WIDTH:0] sum;

    assign sum = {a[`NUM_WIDTH-1], a} + {b[`NUM_WIDTH-1], b};

    always_comb begin
        s = sum[`NUM_WIDTH-1:0];
        // Guard bit differing from the MSB means overflow; guard bit is the true sign.
        if (sum[`NUM_WIDTH] != sum[`NUM_WIDTH-1])
            s = sum[`NUM_WIDTH] ? NUM_MIN : NUM_MAX;
    end
endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: one x/w pair per cycle into a saturating accumulator,
// then optional ReLU and a held, handshaked result.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   start, bias          : begin a dot product with acc = bias (IDLE only)
//   in_valid/in_ready    : x/w pair handshake (ready only while accumulating)
//   x, w                 : activation and weight operands
//   out_valid/out_ready  : result handshake; out_val held until taken
//   out_val              : activated dot product (registered)
//   busy                 : high whenever not IDLE

module neuron_mac_seq
    import neuron_mac_seq_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int RELU    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [`NUM_WIDTH-1:0] bias,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [`NUM_WIDTH-1:0] x,
    input  logic [`NUM_WIDTH-1:0] w,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [`NUM_WIDTH-1:0] out_val,
    output logic                  busy
);
    localparam int              CNT_W    = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    state_t                 state_q, state_d;
    logic [`NUM_WIDTH-1:0]  acc_q, prod, sum;
    logic [CNT_W-1:0]       cnt_q;
    logic                   take;

    mul_sat_comb u_mul (.a(x),     .b(w),    .p(prod));
    add_sat_comb u_add (.a(acc_q), .b(prod), .s(sum));

    assign take = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: if (start) state_d = ST_ACC;
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && cnt_q == CNT_LAST) state_d = ST_ACT;
            end
            ST_ACT:  state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_val   <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (start) begin
                    acc_q <= bias;
                    cnt_q <= '0;
                end
                ST_ACC: if (take) begin
                    acc_q <= sum;
                    // Wrap on the last term so cnt never leaves 0..N_TERMS-1.
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                end
                ST_ACT: begin
                    out_val   <= (RELU != 0 && acc_q[`NUM_WIDTH-1]) ? '0 : acc_q;
                    out_valid <= 1'b1;
                end
                ST_HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
